// File: rtl/pc_pkg.sv
// pc_pkg
// Shared definitions for the program-counter sequencer.
//   sel_e    : next-PC source chosen each cycle
//   sp_width : width of a stack pointer able to count 0..depth
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_BR,
        SEL_JMP,
        SEL_CALL,
        SEL_RET
    } sel_e;

    // The pointer must represent both "empty" (0) and "full" (depth).
    function automatic int sp_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack
// Return-address LIFO used by calls and returns.
// Parameters: WIDTH (entry width), DEPTH (number of entries, >= 1)
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset (pointer only, contents kept)
//   push  in   write din on top (ignored when full)
//   pop   in   discard top entry (ignored when empty)
//   din   in   value to push
//   dout  out  current top entry (valid only when not empty)
//   full  out  registered, DEPTH entries held
//   empty out  registered, no entries held
module ret_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int SPW = sp_width(DEPTH);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] DEPTH_SP = SPW'(DEPTH);
    localparam logic [SPW-1:0] ONE_SP   = SPW'(1);

    logic [WIDTH-1:0] mem [0:(2**AW)-1];
    logic [SPW-1:0]   sp;

    // The top entry sits one below the pointer; the value is meaningless
    // while empty, and callers only consult it when a pop is allowed.
    assign dout = mem[AW'(sp - ONE_SP)];

    // Pointer, storage and the registered full/empty flags move together so
    // the flags always describe the pointer value after the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (push && !full) begin
            mem[AW'(sp)] <= din;
            sp           <= sp + ONE_SP;
            empty        <= 1'b0;
            full         <= ((sp + ONE_SP) == DEPTH_SP);
        end else if (pop && !empty) begin
            sp    <= sp - ONE_SP;
            full  <= 1'b0;
            empty <= (sp == ONE_SP);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter register and next-PC selection for the fetch stage:
// sequential increment, PC-relative branch, absolute jump, call and return,
// with a return-address stack and a sticky fault flag.
// Parameters: WIDTH, STEP, RESET_VECTOR, STACK_DEPTH
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   stall       in   hold PC, stack and fault
//   br_taken    in   PC <= PC + br_offset
//   br_offset   in   two's-complement byte offset
//   jmp         in   PC <= jmp_addr
//   call        in   push PC+STEP, PC <= jmp_addr
//   ret         in   PC <= popped stack top
//   jmp_addr    in   jump/call target
//   pc          out  current PC (registered)
//   pc_next     out  PC + STEP (combinational link value)
//   stack_full  out  stack holds STACK_DEPTH entries
//   stack_empty out  stack holds no entries
//   fault       out  sticky overflow / underflow / call+ret conflict
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               STEP         = 2,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STACK_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_offset,
    input  logic             jmp,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jmp_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             fault
);

    sel_e             sel;
    logic             faultSet;
    logic [WIDTH-1:0] stackTop;
    logic             push;
    logic             pop;

    assign pc_next = pc + WIDTH'(STEP);
    assign push    = (sel == SEL_CALL);
    assign pop     = (sel == SEL_RET);

    // Next-PC source in priority order. Illegal requests (conflict,
    // overflow, underflow) fall back to holding the PC and raise a fault.
    always_comb begin
        sel      = SEL_INC;
        faultSet = 1'b0;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (call && ret) begin
            sel      = SEL_HOLD;
            faultSet = 1'b1;
        end else if (ret) begin
            if (stack_empty) begin
                sel      = SEL_HOLD;
                faultSet = 1'b1;
            end else begin
                sel = SEL_RET;
            end
        end else if (call) begin
            if (stack_full) begin
                sel      = SEL_HOLD;
                faultSet = 1'b1;
            end else begin
                sel = SEL_CALL;
            end
        end else if (jmp) begin
            sel = SEL_JMP;
        end else if (br_taken) begin
            sel = SEL_BR;
        end
    end

    // PC register and sticky fault; only reset clears the fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_VECTOR;
            fault <= 1'b0;
        end else begin
            fault <= fault | faultSet;
            case (sel)
                SEL_INC:  pc <= pc_next;
                SEL_BR:   pc <= pc + br_offset;
                SEL_JMP:  pc <= jmp_addr;
                SEL_CALL: pc <= jmp_addr;
                SEL_RET:  pc <= stackTop;
                default:  pc <= pc;
            endcase
        end
    end

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_next),
        .dout  (stackTop),
        .full  (stack_full),
        .empty (stack_empty)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer with RESET_VECTOR = 0x0100, STACK_DEPTH = 4.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jmp;
    logic        call;
    logic        ret;
    logic [15:0] jmp_addr;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic        stack_full;
    logic        stack_empty;
    logic        fault;

    int checks = 0;
    int passed = 0;

    pc_sequencer #(
        .WIDTH        (16),
        .STEP         (2),
        .RESET_VECTOR (16'h0100),
        .STACK_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .jmp         (jmp),
        .call        (call),
        .ret         (ret),
        .jmp_addr    (jmp_addr),
        .pc          (pc),
        .pc_next     (pc_next),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Drive one cycle of controls, let the edge take them, then drop the
    // pulses 1 time unit after the edge so outputs are sampled settled.
    task automatic applyStimulus(input logic r, input logic s, input logic j,
                                 input logic c, input logic rt, input logic b,
                                 input logic [15:0] addr, input logic [15:0] off);
        rst       = r;
        stall     = s;
        jmp       = j;
        call      = c;
        ret       = rt;
        br_taken  = b;
        jmp_addr  = addr;
        br_offset = off;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        stall    = 1'b0;
        jmp      = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
        br_taken = 1'b0; jmp_addr = '0; br_offset = '0;

        // reset and sequential fetch
        applyStimulus(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        applyStimulus(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        checkOutput("rst_pc", pc, 16'h0100);
        checkOutput("rst_pc_next", pc_next, 16'h0102);
        checkOutput("rst_empty", 16'(stack_empty), 16'h1);
        checkOutput("rst_full", 16'(stack_full), 16'h0);
        checkOutput("rst_fault", 16'(fault), 16'h0);
        idle(); checkOutput("inc1", pc, 16'h0102);
        idle(); checkOutput("inc2", pc, 16'h0104);
        idle(); checkOutput("inc3", pc, 16'h0106);
        checkOutput("inc_empty", 16'(stack_empty), 16'h1);

        // wrap and negative branch
        applyStimulus(0, 0, 1, 0, 0, 0, 16'hFFFE, 16'h0000);
        checkOutput("jmp_top", pc, 16'hFFFE);
        checkOutput("pc_next_wrap", pc_next, 16'h0000);
        idle(); checkOutput("inc_wrap", pc, 16'h0000);
        applyStimulus(0, 0, 1, 0, 0, 0, 16'h0010, 16'h0000);
        applyStimulus(0, 0, 0, 0, 0, 1, 16'h0000, 16'hFFF0);
        checkOutput("br_neg", pc, 16'h0000);

        // single call / return
        applyStimulus(0, 0, 1, 0, 0, 0, 16'h0040, 16'h0000);
        applyStimulus(0, 0, 0, 1, 0, 0, 16'h0200, 16'h0000);
        checkOutput("call_pc", pc, 16'h0200);
        checkOutput("call_empty", 16'(stack_empty), 16'h0);
        applyStimulus(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        checkOutput("ret_pc", pc, 16'h0042);
        checkOutput("ret_empty", 16'(stack_empty), 16'h1);

        // nested calls to full, overflow, LIFO unwinding
        applyStimulus(0, 0, 0, 1, 0, 0, 16'h1000, 16'h0000);
        applyStimulus(0, 0, 0, 1, 0, 0, 16'h2000, 16'h0000);
        applyStimulus(0, 0, 0, 1, 0, 0, 16'h3000, 16'h0000);
        checkOutput("nest3_full", 16'(stack_full), 16'h0);
        applyStimulus(0, 0, 0, 1, 0, 0, 16'h4000, 16'h0000);
        checkOutput("nest4_pc", pc, 16'h4000);
        checkOutput("nest4_full", 16'(stack_full), 16'h1);
        checkOutput("nest4_fault", 16'(fault), 16'h0);
        applyStimulus(0, 0, 0, 1, 0, 0, 16'h5000, 16'h0000);
        checkOutput("ovf_pc", pc, 16'h4000);
        checkOutput("ovf_fault", 16'(fault), 16'h1);
        applyStimulus(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        checkOutput("lifo1", pc, 16'h3002);
        checkOutput("lifo1_full", 16'(stack_full), 16'h0);
        applyStimulus(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        checkOutput("lifo2", pc, 16'h2002);
        applyStimulus(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        checkOutput("lifo3", pc, 16'h1002);
        applyStimulus(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        checkOutput("lifo4", pc, 16'h0044);
        checkOutput("lifo4_empty", 16'(stack_empty), 16'h1);
        checkOutput("lifo4_fault", 16'(fault), 16'h1);

        // underflow and sticky fault
        applyStimulus(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        checkOutput("rst2_fault", 16'(fault), 16'h0);
        applyStimulus(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        checkOutput("unf_pc", pc, 16'h0100);
        checkOutput("unf_fault", 16'(fault), 16'h1);
        idle(); checkOutput("sticky_pc", pc, 16'h0102);
        checkOutput("sticky_fault", 16'(fault), 16'h1);

        // call+ret conflict
        applyStimulus(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 0, 0, 1, 0, 0, 16'h0300, 16'h0000);
        checkOutput("call2_pc", pc, 16'h0300);
        applyStimulus(0, 0, 0, 1, 1, 0, 16'h0400, 16'h0000);
        checkOutput("conf_pc", pc, 16'h0300);
        checkOutput("conf_fault", 16'(fault), 16'h1);
        checkOutput("conf_empty", 16'(stack_empty), 16'h0);

        // stall holds everything
        applyStimulus(0, 1, 1, 0, 0, 0, 16'h0500, 16'h0000);
        checkOutput("stall1_pc", pc, 16'h0300);
        applyStimulus(0, 1, 0, 1, 0, 0, 16'h0600, 16'h0000);
        checkOutput("stall2_pc", pc, 16'h0300);
        checkOutput("stall2_full", 16'(stack_full), 16'h0);
        applyStimulus(0, 1, 0, 0, 1, 0, 16'h0000, 16'h0000);
        checkOutput("stall3_pc", pc, 16'h0300);
        checkOutput("stall3_empty", 16'(stack_empty), 16'h0);
        applyStimulus(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        checkOutput("post_stall_ret", pc, 16'h0102);
        checkOutput("post_stall_empty", 16'(stack_empty), 16'h1);

        // reset beats a simultaneous call
        applyStimulus(1, 0, 0, 1, 0, 0, 16'h0700, 16'h0000);
        checkOutput("rstcall_pc", pc, 16'h0100);
        checkOutput("rstcall_empty", 16'(stack_empty), 16'h1);
        checkOutput("rstcall_fault", 16'(fault), 16'h0);
        applyStimulus(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
        checkOutput("rstcall_nopush_pc", pc, 16'h0100);
        checkOutput("rstcall_nopush_fault", 16'(fault), 16'h1);
        idle(); checkOutput("final_inc", pc, 16'h0102);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer that replaces the fixed PC+2 adder in the fetch stage. Holds the PC register and selects the next PC from sequential increment, PC-relative branch, absolute jump, call, or return. Calls and returns use a small internal return-address stack. Stall handling and sticky fault reporting are included.

## Interface
- WIDTH, 16, PC and address width in bits.
- STEP, 2, increment per sequential fetch (instruction size in bytes).
- RESET_VECTOR, 0, PC value loaded on reset (WIDTH bits).
- STACK_DEPTH, 4, return-address stack entries (≥1).
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- STALL  in  1  hold PC and stack this cycle.
- BR_TAKEN  in  1  take PC-relative branch.
- BR_OFFSET  in  WIDTH  two's-complement byte offset added to current PC.
- JMP  in  1  absolute jump to JMP_ADDR.
- CALL  in  1  jump to JMP_ADDR and push PC+STEP.
- RET  in  1  pop stack top into PC.
- JMP_ADDR  in  WIDTH  jump/call target.
- PC  out  WIDTH  current PC (registered).
- PC_NEXT  out  WIDTH  PC+STEP (combinational from PC), used as link value.
- STACK_FULL  out  1  stack holds STACK_DEPTH entries.
- STACK_EMPTY  out  1  stack holds 0 entries.
- FAULT  out  1  sticky: stack overflow, underflow, or CALL+RET conflict.

## Operation
- Priority, highest first: RST, STALL, conflict (CALL&RET), RET, CALL, JMP, BR_TAKEN, increment.
- RST: PC=RESET_VECTOR, stack pointer=0, FAULT=0. Stack contents are not cleared.
- STALL: PC, stack and FAULT hold. All other controls are ignored.
- CALL&RET both high: PC holds, no push or pop, FAULT=1.
- RET, stack non-empty: PC=top entry, pointer−1.
- RET, stack empty: PC holds, FAULT=1.
- CALL, stack not full: push PC+STEP, PC=JMP_ADDR, pointer+1.
- CALL, stack full: no push, PC holds, FAULT=1.
- JMP: PC=JMP_ADDR. The stack is untouched.
- BR_TAKEN: PC=PC+BR_OFFSET, modulo 2^WIDTH.
- Otherwise: PC=PC+STEP, modulo 2^WIDTH. Wrap from 2^WIDTH−STEP goes to 0.
- Arithmetic is WIDTH bits; carries are discarded. There is no alignment check.
- FAULT clears only on RST. PC keeps operating normally after a fault.
- Select states (pc_pkg enum): SEL_HOLD, SEL_INC, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET.

## Timing
- PC changes one cycle after the control is sampled. Every control is a single-cycle pulse.
- Back-to-back CALL/RET on consecutive cycles is legal. Each cycle's push/pop sees the pointer updated by the previous cycle.
- PC_NEXT has zero latency from PC.
- STACK_FULL, STACK_EMPTY and FAULT are registered and reflect the state after the edge.
- Reset values: PC=RESET_VECTOR, PC_NEXT=RESET_VECTOR+STEP, STACK_EMPTY=1, STACK_FULL=0, FAULT=0.
- RST asserted mid-sequence (e.g. with CALL) wins. No push occurs; pointer=0 next cycle.

## Structure
- pc_pkg: select enum, stack-pointer width function (clog2(STACK_DEPTH+1)).
- Sub-module ret_stack: LIFO with push/pop/full/empty and STACK_DEPTH, WIDTH parameters. pc_sequencer contains the next-PC mux, PC register and fault logic.

## Test plan
- Reset with RESET_VECTOR=0x0100, then 3 idle cycles -> PC 0x0100, 0x0102, 0x0104, 0x0106; STACK_EMPTY=1.
- PC=0xFFFE, idle -> PC=0x0000. PC=0x0010, BR_TAKEN with offset 0xFFF0 -> PC=0x0000.
- CALL 0x0200 from PC=0x0040 -> PC=0x0200, STACK_EMPTY=0. RET -> PC=0x0042, STACK_EMPTY=1.
- Four nested CALLs (DEPTH=4) -> STACK_FULL=1. A fifth CALL -> PC holds, FAULT=1. Four RETs return in LIFO order.
- RET on an empty stack -> PC holds, FAULT=1. FAULT stays 1 until RST. CALL&RET together -> PC holds, FAULT=1.
- STALL held 3 cycles with JMP/CALL pulses -> PC and pointer unchanged. RST together with CALL -> PC=RESET_VECTOR, STACK_EMPTY=1.
